// File: rtl/rr_decode_arbiter_if.sv
// Request/grant bundle between the requesters and the round-robin arbiter.
//   en       : global arbiter enable (requester side drives)
//   req[7:0] : per-requester request lines (requester side drives)
//   gnt_vld  : a grant is currently active (arbiter drives)
//   gnt_idx  : index of the current or most recent owner (arbiter drives)
//   gnt[7:0] : one-hot decode of gnt_idx, zero when no grant (arbiter drives)
//   timeout  : one-cycle pulse when a grant is revoked by the hold limit
//   busy     : arbiter is in its owned state (same as gnt_vld)
interface rr_decode_arbiter_if;
    logic       en;
    logic [7:0] req;
    logic       gnt_vld;
    logic [2:0] gnt_idx;
    logic [7:0] gnt;
    logic       timeout;
    logic       busy;

    modport master (
        output en, req,
        input  gnt_vld, gnt_idx, gnt, timeout, busy
    );

    modport slave (
        input  en, req,
        output gnt_vld, gnt_idx, gnt, timeout, busy
    );
endinterface

// File: rtl/rr_decode_arbiter.sv
// Round-robin arbiter sharing one resource among 8 requesters, with a
// bounded hold time and a 3-to-8 decoded grant vector.
//   clk   : system clock, rising edge
//   rst_n : asynchronous active-low reset
//   bus   : rr_decode_arbiter_if.slave (en, req in; gnt_vld, gnt_idx,
//           gnt, timeout, busy out)
// HOLD_MAX : maximum consecutive grant cycles, 0 disables the limit
// CW       : hold-counter width, HOLD_MAX must fit in CW bits
module rr_decode_arbiter #(
    parameter int unsigned HOLD_MAX = 15,
    parameter int unsigned CW       = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    rr_decode_arbiter_if.slave bus
);

    localparam int unsigned IW        = 3;
    localparam bit          HOLD_EN   = (HOLD_MAX != 0);
    localparam logic [CW-1:0] HOLD_LAST = CW'(HOLD_MAX - 1);

    typedef enum logic {
        IDLE = 1'b0,
        OWN  = 1'b1
    } state_t;

    state_t          state_q, state_d;
    logic [IW-1:0]   idx_q, idx_d;
    logic [IW-1:0]   last_q, last_d;
    logic [CW-1:0]   cnt_q, cnt_d;
    logic            timeout_q, timeout_d;

    logic [IW-1:0]   win_c;
    logic [IW-1:0]   cand_c;
    logic            found_c;

    // First set request scanning last+1, last+2, ... with wrap-around.
    always_comb begin
        win_c   = last_q;
        cand_c  = '0;
        found_c = 1'b0;
        for (int i = 1; i <= 8; i++) begin
            cand_c = last_q + IW'(i);
            if (!found_c && bus.req[cand_c]) begin
                win_c   = cand_c;
                found_c = 1'b1;
            end
        end
    end

    // Next-state: grant in IDLE; in OWN exit on disable, release, then hold limit.
    always_comb begin
        state_d   = state_q;
        idx_d     = idx_q;
        last_d    = last_q;
        cnt_d     = cnt_q;
        timeout_d = 1'b0;
        case (state_q)
            IDLE: begin
                if (bus.en && found_c) begin
                    idx_d   = win_c;
                    last_d  = win_c;
                    cnt_d   = '0;
                    state_d = OWN;
                end
            end
            OWN: begin
                if (!bus.en) begin
                    state_d = IDLE;
                end else if (!bus.req[idx_q]) begin
                    state_d = IDLE;
                end else if (HOLD_EN && (cnt_q == HOLD_LAST)) begin
                    state_d   = IDLE;
                    timeout_d = 1'b1;
                end else begin
                    cnt_d = cnt_q + CW'(1);
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // State and datapath registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= IDLE;
            idx_q     <= '0;
            last_q    <= IW'(7);
            cnt_q     <= '0;
            timeout_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            idx_q     <= idx_d;
            last_q    <= last_d;
            cnt_q     <= cnt_d;
            timeout_q <= timeout_d;
        end
    end

    // Outputs are the registers themselves or decodes of them.
    assign bus.gnt_vld = (state_q == OWN);
    assign bus.busy    = (state_q == OWN);
    assign bus.gnt_idx = idx_q;
    assign bus.gnt     = (state_q == OWN) ? (8'b1 << idx_q) : 8'h00;
    assign bus.timeout = timeout_q;

endmodule

// File: tb/tb_rr_decode_arbiter.sv
// Directed bench for rr_decode_arbiter: three instances share clk/rst_n,
// one per hold limit (15, 4, 3). Observed outputs are packed as
// {gnt_vld, gnt_idx, gnt, timeout, busy} and compared against hand values.
module tb_rr_decode_arbiter;

    logic clk = 1'b0;
    logic rst_n;
    int   n_cmp = 0;
    int   n_err = 0;
    logic [13:0] exp_v;

    always #5 clk = ~clk;

    rr_decode_arbiter_if b15 ();
    rr_decode_arbiter_if b4 ();
    rr_decode_arbiter_if b3 ();

    rr_decode_arbiter #(.HOLD_MAX(15), .CW(4)) u15 (.clk(clk), .rst_n(rst_n), .bus(b15));
    rr_decode_arbiter #(.HOLD_MAX(4),  .CW(4)) u4  (.clk(clk), .rst_n(rst_n), .bus(b4));
    rr_decode_arbiter #(.HOLD_MAX(3),  .CW(4)) u3  (.clk(clk), .rst_n(rst_n), .bus(b3));

    wire [13:0] obs15 = {b15.gnt_vld, b15.gnt_idx, b15.gnt, b15.timeout, b15.busy};
    wire [13:0] obs4  = {b4.gnt_vld,  b4.gnt_idx,  b4.gnt,  b4.timeout,  b4.busy};
    wire [13:0] obs3  = {b3.gnt_vld,  b3.gnt_idx,  b3.gnt,  b3.timeout,  b3.busy};

    // Expected packed output word for a given grant state.
    function automatic logic [13:0] pk(input logic vld, input logic [2:0] idx, input logic to);
        logic [7:0] g;
        g = vld ? (8'b1 << idx) : 8'h00;
        return {vld, idx, g, to, vld};
    endfunction

    task automatic step;
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset;
        rst_n = 1'b0;
        step();
        rst_n = 1'b1;
    endtask

    task automatic test_reset;
        exp_v = pk(1'b0, 3'd0, 1'b0);
        n_cmp++; if (obs15 !== exp_v) begin n_err++; $display("FAIL reset_u15: got %h want %h", obs15, exp_v); end
        n_cmp++; if (obs4 !== exp_v)  begin n_err++; $display("FAIL reset_u4: got %h want %h", obs4, exp_v); end
        n_cmp++; if (obs3 !== exp_v)  begin n_err++; $display("FAIL reset_u3: got %h want %h", obs3, exp_v); end
    endtask

    task automatic test_single;
        b15.req = 8'h04;
        #1;
        exp_v = pk(1'b0, 3'd0, 1'b0);
        n_cmp++; if (obs15 !== exp_v) begin n_err++; $display("FAIL single_pre: got %h want %h", obs15, exp_v); end
        for (int c = 0; c < 5; c++) begin
            step();
            exp_v = pk(1'b1, 3'd2, 1'b0);
            n_cmp++; if (obs15 !== exp_v) begin n_err++; $display("FAIL single_hold[%0d]: got %h want %h", c, obs15, exp_v); end
        end
        b15.req = 8'h00;
        step();
        exp_v = pk(1'b0, 3'd2, 1'b0);
        n_cmp++; if (obs15 !== exp_v) begin n_err++; $display("FAIL single_drop: got %h want %h", obs15, exp_v); end
    endtask

    task automatic test_round_robin;
        logic [2:0] k;
        for (int i = 0; i < 9; i++) begin
            k = 3'(i);
            b15.req = 8'hFF;
            step();
            exp_v = pk(1'b1, k, 1'b0);
            n_cmp++; if (obs15 !== exp_v) begin n_err++; $display("FAIL rr_grant[%0d]: got %h want %h", i, obs15, exp_v); end
            step();
            n_cmp++; if (obs15 !== exp_v) begin n_err++; $display("FAIL rr_hold[%0d]: got %h want %h", i, obs15, exp_v); end
            b15.req = 8'hFF & ~(8'b1 << k);
            step();
            exp_v = pk(1'b0, k, 1'b0);
            n_cmp++; if (obs15 !== exp_v) begin n_err++; $display("FAIL rr_gap[%0d]: got %h want %h", i, obs15, exp_v); end
        end
        b15.req = 8'h00;
        step();
    endtask

    task automatic test_wrap;
        b15.req = 8'h40;
        step();
        exp_v = pk(1'b1, 3'd6, 1'b0);
        n_cmp++; if (obs15 !== exp_v) begin n_err++; $display("FAIL wrap_g6: got %h want %h", obs15, exp_v); end
        b15.req = 8'h00;
        step();
        b15.req = 8'h81;
        step();
        exp_v = pk(1'b1, 3'd7, 1'b0);
        n_cmp++; if (obs15 !== exp_v) begin n_err++; $display("FAIL wrap_g7: got %h want %h", obs15, exp_v); end
        b15.req = 8'h01;
        step();
        exp_v = pk(1'b0, 3'd7, 1'b0);
        n_cmp++; if (obs15 !== exp_v) begin n_err++; $display("FAIL wrap_gap: got %h want %h", obs15, exp_v); end
        step();
        exp_v = pk(1'b1, 3'd0, 1'b0);
        n_cmp++; if (obs15 !== exp_v) begin n_err++; $display("FAIL wrap_g0: got %h want %h", obs15, exp_v); end
        b15.req = 8'h00;
        step();
        exp_v = pk(1'b0, 3'd0, 1'b0);
        n_cmp++; if (obs15 !== exp_v) begin n_err++; $display("FAIL wrap_end: got %h want %h", obs15, exp_v); end
    endtask

    task automatic test_timeout;
        b4.req = 8'h09;
        for (int c = 0; c < 4; c++) begin
            step();
            exp_v = pk(1'b1, 3'd0, 1'b0);
            n_cmp++; if (obs4 !== exp_v) begin n_err++; $display("FAIL to_hold0[%0d]: got %h want %h", c, obs4, exp_v); end
        end
        step();
        exp_v = pk(1'b0, 3'd0, 1'b1);
        n_cmp++; if (obs4 !== exp_v) begin n_err++; $display("FAIL to_pulse0: got %h want %h", obs4, exp_v); end
        step();
        exp_v = pk(1'b1, 3'd3, 1'b0);
        n_cmp++; if (obs4 !== exp_v) begin n_err++; $display("FAIL to_next3: got %h want %h", obs4, exp_v); end
        b4.req = 8'h01;
        step();
        exp_v = pk(1'b0, 3'd3, 1'b0);
        n_cmp++; if (obs4 !== exp_v) begin n_err++; $display("FAIL to_rel3: got %h want %h", obs4, exp_v); end
        for (int c = 0; c < 4; c++) begin
            step();
            exp_v = pk(1'b1, 3'd0, 1'b0);
            n_cmp++; if (obs4 !== exp_v) begin n_err++; $display("FAIL to_solo[%0d]: got %h want %h", c, obs4, exp_v); end
        end
        step();
        exp_v = pk(1'b0, 3'd0, 1'b1);
        n_cmp++; if (obs4 !== exp_v) begin n_err++; $display("FAIL to_solo_pulse: got %h want %h", obs4, exp_v); end
        step();
        exp_v = pk(1'b1, 3'd0, 1'b0);
        n_cmp++; if (obs4 !== exp_v) begin n_err++; $display("FAIL to_regrant: got %h want %h", obs4, exp_v); end
        b4.req = 8'h00;
        step();
        exp_v = pk(1'b0, 3'd0, 1'b0);
        n_cmp++; if (obs4 !== exp_v) begin n_err++; $display("FAIL to_end: got %h want %h", obs4, exp_v); end
    endtask

    task automatic test_enable_reset;
        b15.req = 8'h10;
        step();
        exp_v = pk(1'b1, 3'd4, 1'b0);
        n_cmp++; if (obs15 !== exp_v) begin n_err++; $display("FAIL en_grant: got %h want %h", obs15, exp_v); end
        b15.en = 1'b0;
        for (int c = 0; c < 3; c++) begin
            step();
            exp_v = pk(1'b0, 3'd4, 1'b0);
            n_cmp++; if (obs15 !== exp_v) begin n_err++; $display("FAIL en_off[%0d]: got %h want %h", c, obs15, exp_v); end
        end
        b15.en = 1'b1;
        step();
        exp_v = pk(1'b1, 3'd4, 1'b0);
        n_cmp++; if (obs15 !== exp_v) begin n_err++; $display("FAIL en_regrant: got %h want %h", obs15, exp_v); end
        rst_n = 1'b0;
        #1;
        exp_v = pk(1'b0, 3'd0, 1'b0);
        n_cmp++; if (obs15 !== exp_v) begin n_err++; $display("FAIL rst_async: got %h want %h", obs15, exp_v); end
        step();
        rst_n   = 1'b1;
        b15.req = 8'h80;
        step();
        exp_v = pk(1'b1, 3'd7, 1'b0);
        n_cmp++; if (obs15 !== exp_v) begin n_err++; $display("FAIL rst_first7: got %h want %h", obs15, exp_v); end
        b15.req = 8'h00;
        step();
    endtask

    task automatic test_coincide;
        b3.req = 8'h02;
        for (int c = 0; c < 3; c++) begin
            step();
            exp_v = pk(1'b1, 3'd1, 1'b0);
            n_cmp++; if (obs3 !== exp_v) begin n_err++; $display("FAIL co_hold[%0d]: got %h want %h", c, obs3, exp_v); end
        end
        b3.req = 8'h00;
        step();
        exp_v = pk(1'b0, 3'd1, 1'b0);
        n_cmp++; if (obs3 !== exp_v) begin n_err++; $display("FAIL co_release: got %h want %h", obs3, exp_v); end
        b3.req = 8'h02;
        for (int c = 0; c < 3; c++) begin
            step();
            exp_v = pk(1'b1, 3'd1, 1'b0);
            n_cmp++; if (obs3 !== exp_v) begin n_err++; $display("FAIL co_hold2[%0d]: got %h want %h", c, obs3, exp_v); end
        end
        step();
        exp_v = pk(1'b0, 3'd1, 1'b1);
        n_cmp++; if (obs3 !== exp_v) begin n_err++; $display("FAIL co_timeout: got %h want %h", obs3, exp_v); end
        b3.req = 8'h00;
        step();
    endtask

    initial begin
        rst_n   = 1'b0;
        b15.en  = 1'b1; b15.req = 8'h00;
        b4.en   = 1'b1; b4.req  = 8'h00;
        b3.en   = 1'b1; b3.req  = 8'h00;
        step();
        step();
        test_reset();
        rst_n = 1'b1;
        test_single();
        do_reset();
        test_round_robin();
        test_wrap();
        test_timeout();
        test_enable_reset();
        test_coincide();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
